// File: rtl/disp_page_sched_if.sv
// -----------------------------------------------------------------------------
// disp_page_sched_if
// Bundles the configuration, button, message-handshake and display-status
// signals of the display page scheduler.
//   cfg_we/cfg_addr/cfg_wdata : dwell register write port
//   btn_next                  : one-cycle "next page" pulse
//   btn_hold                  : level, freezes rotation while high
//   msg_req / msg_ack         : message page request / acceptance pulse
//   msg_done                  : pulse when the message dwell expires
//   page_sel/disp_time        : selected page, high on the time page
//   sec_left                  : seconds remaining on the current page
//   page_change               : pulse on every page load
// Modports: master = environment side, slave = scheduler side.
// -----------------------------------------------------------------------------
interface disp_page_sched_if;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic       btn_next;
   logic       btn_hold;
   logic       msg_req;
   logic       msg_ack;
   logic       msg_done;
   logic [1:0] page_sel;
   logic       disp_time;
   logic [7:0] sec_left;
   logic       page_change;

   modport master (
      output cfg_we, cfg_addr, cfg_wdata, btn_next, btn_hold, msg_req,
      input  msg_ack, msg_done, page_sel, disp_time, sec_left, page_change
   );

   modport slave (
      input  cfg_we, cfg_addr, cfg_wdata, btn_next, btn_hold, msg_req,
      output msg_ack, msg_done, page_sel, disp_time, sec_left, page_change
   );
endinterface

// File: rtl/disp_page_sched.sv
// -----------------------------------------------------------------------------
// disp_page_sched
// Chooses which source the 8-digit display shows: time (0), humidity (1),
// temperature (2) or a Bluetooth message page (3). Each rotation page has a
// programmable dwell in seconds; btn_next advances, btn_hold freezes the
// countdown, and message pages are admitted through a req/ack handshake.
// Ports:
//   clk   : system clock
//   arstn : asynchronous reset, active-low
//   bus   : disp_page_sched_if.slave (config, buttons, message handshake,
//           page_sel/disp_time/sec_left/page_change status, all registered)
// Optional build macro:
//   DISP_MSG_PREEMPT_EN : when defined, msg_req is taken immediately in
//   ROTATE or HOLD; otherwise only at a rotation advance outside HOLD.
// -----------------------------------------------------------------------------
module disp_page_sched #(
   parameter int TICK_DIV      = 20000000,
   parameter int DWELL_RST     = 5,
   parameter int MSG_DWELL_RST = 3
) (
   input logic              clk,
   input logic              arstn,
   disp_page_sched_if.slave bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {ROTATE, HOLD, MSG} state_t;

   state_t        state, state_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic [7:0]    dwell0, dwell1, dwell2, msg_dwell, msg_eff;
   logic [1:0]    rot_page, rot_page_nxt;
   logic [1:0]    page_sel_nxt;
   logic [7:0]    sec_left_nxt;
   logic          ack_nxt, done_nxt, chg_nxt;
   logic          tick, frozen, expire, adv, take_msg, all_zero;
   logic [2:0]    np;

   function automatic logic [7:0] dwell_of(input logic [1:0] p,
                                           input logic [7:0] d0,
                                           input logic [7:0] d1,
                                           input logic [7:0] d2);
      case (p)
         2'd1:    dwell_of = d1;
         2'd2:    dwell_of = d2;
         default: dwell_of = d0;
      endcase
   endfunction

   // Returns {found, page}: first nonzero-dwell page after cur (0->1->2->0),
   // falling back to cur itself; found=0 means every dwell is zero.
   function automatic logic [2:0] next_page(input logic [1:0] cur,
                                            input logic [7:0] d0,
                                            input logic [7:0] d1,
                                            input logic [7:0] d2);
      logic [1:0] c1, c2;
      c1 = (cur == 2'd2) ? 2'd0 : cur + 2'd1;
      c2 = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
      if (dwell_of(c1, d0, d1, d2) != 8'd0)
         next_page = {1'b1, c1};
      else if (dwell_of(c2, d0, d1, d2) != 8'd0)
         next_page = {1'b1, c2};
      else if (dwell_of(cur, d0, d1, d2) != 8'd0)
         next_page = {1'b1, cur};
      else
         next_page = 3'b000;
   endfunction

   assign tick     = (presc == PW'(TICK_DIV - 1));
   assign np       = next_page(rot_page, dwell0, dwell1, dwell2);
   assign all_zero = ~np[2];
   assign msg_eff  = (msg_dwell == 8'd0) ? 8'd1 : msg_dwell;

   // btn_hold freezes the countdown in the very cycle it is first sampled.
   assign frozen = (state == HOLD) || ((state == ROTATE) && bus.btn_hold);

   // sec_left==0 with some nonzero dwell happens only when a zero-dwell page
   // was reloaded after a message; let it move on at the next tick.
   assign expire = (state != MSG) && !frozen && tick &&
                   ((bus.sec_left == 8'd1) ||
                    ((bus.sec_left == 8'd0) && !all_zero));
   assign adv    = expire || ((state != MSG) && bus.btn_next && !all_zero);

`ifdef DISP_MSG_PREEMPT_EN
   assign take_msg = (state != MSG) && bus.msg_req;
`else
   assign take_msg = bus.msg_req && adv && !frozen;
`endif

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) state <= ROTATE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      presc_nxt    = presc;
      rot_page_nxt = rot_page;
      page_sel_nxt = bus.page_sel;
      sec_left_nxt = bus.sec_left;
      ack_nxt      = 1'b0;
      done_nxt     = 1'b0;
      chg_nxt      = 1'b0;
      case (state)
         MSG: begin
            presc_nxt = tick ? '0 : presc + 1'b1;
            if (tick) begin
               if (bus.sec_left <= 8'd1) begin
                  // rot_page still holds the interrupted page
                  done_nxt     = 1'b1;
                  chg_nxt      = 1'b1;
                  page_sel_nxt = rot_page;
                  sec_left_nxt = dwell_of(rot_page, dwell0, dwell1, dwell2);
                  state_nxt    = bus.btn_hold ? HOLD : ROTATE;
               end else begin
                  sec_left_nxt = bus.sec_left - 8'd1;
               end
            end
         end
         default: begin
            if (take_msg) begin
               ack_nxt      = 1'b1;
               chg_nxt      = 1'b1;
               page_sel_nxt = 2'd3;
               sec_left_nxt = msg_eff;
               presc_nxt    = '0;
               state_nxt    = MSG;
            end else begin
               state_nxt = bus.btn_hold ? HOLD : ROTATE;
               if (adv) begin
                  chg_nxt      = 1'b1;
                  rot_page_nxt = np[1:0];
                  page_sel_nxt = np[1:0];
                  sec_left_nxt = dwell_of(np[1:0], dwell0, dwell1, dwell2);
                  presc_nxt    = '0;
               end else if (!frozen) begin
                  presc_nxt = tick ? '0 : presc + 1'b1;
                  if (tick && (bus.sec_left != 8'd0))
                     sec_left_nxt = bus.sec_left - 8'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         presc           <= '0;
         rot_page        <= 2'd0;
         bus.page_sel    <= 2'd0;
         bus.disp_time   <= 1'b1;
         bus.sec_left    <= 8'(DWELL_RST);
         bus.msg_ack     <= 1'b0;
         bus.msg_done    <= 1'b0;
         bus.page_change <= 1'b0;
      end else begin
         presc           <= presc_nxt;
         rot_page        <= rot_page_nxt;
         bus.page_sel    <= page_sel_nxt;
         bus.disp_time   <= (page_sel_nxt == 2'd0);
         bus.sec_left    <= sec_left_nxt;
         bus.msg_ack     <= ack_nxt;
         bus.msg_done    <= done_nxt;
         bus.page_change <= chg_nxt;
      end
   end

   // Dwell registers only; a write never touches the running sec_left.
   always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
         dwell0    <= 8'(DWELL_RST);
         dwell1    <= 8'(DWELL_RST);
         dwell2    <= 8'(DWELL_RST);
         msg_dwell <= 8'(MSG_DWELL_RST);
      end else if (bus.cfg_we) begin
         case (bus.cfg_addr)
            2'd0:    dwell0    <= bus.cfg_wdata;
            2'd1:    dwell1    <= bus.cfg_wdata;
            2'd2:    dwell2    <= bus.cfg_wdata;
            default: msg_dwell <= bus.cfg_wdata;
         endcase
      end
   end

endmodule

// File: tb/tb_disp_page_sched.sv
// -----------------------------------------------------------------------------
// tb_disp_page_sched
// Directed bench for disp_page_sched with TICK_DIV=4 (one second = 4 clocks).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, i.e. they show the result of the edge just taken.
// -----------------------------------------------------------------------------
module tb_disp_page_sched;
   logic clk = 1'b0;
   logic arstn = 1'b0;
   int   checks = 0;
   int   errors = 0;

   disp_page_sched_if bus_if ();

   disp_page_sched #(
      .TICK_DIV      (4),
      .DWELL_RST     (5),
      .MSG_DWELL_RST (3)
   ) dut (
      .clk   (clk),
      .arstn (arstn),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_inputs();
      bus_if.cfg_we    = 1'b0;
      bus_if.cfg_addr  = 2'd0;
      bus_if.cfg_wdata = 8'd0;
      bus_if.btn_next  = 1'b0;
      bus_if.btn_hold  = 1'b0;
      bus_if.msg_req   = 1'b0;
   endtask

   // Leaves the bench one time unit after the edge that precedes "E1".
   task automatic apply_reset();
      @(posedge clk);
      #1;
      arstn = 1'b0;
      clear_inputs();
      cyc(1);
      arstn = 1'b1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
      bus_if.cfg_we    = 1'b1;
      bus_if.cfg_addr  = a;
      bus_if.cfg_wdata = d;
      cyc(1);
      bus_if.cfg_we    = 1'b0;
   endtask

   initial begin
      clear_inputs();
      // ---- reset values ----
      #12;
      chk("rst_page_sel", bus_if.page_sel, 0);
      chk("rst_disp_time", bus_if.disp_time, 1);
      chk("rst_sec_left", bus_if.sec_left, 5);
      chk("rst_msg_ack", bus_if.msg_ack, 0);
      chk("rst_msg_done", bus_if.msg_done, 0);
      chk("rst_page_change", bus_if.page_change, 0);

      // ---- default rotation 0 -> 1 -> 2 -> 0, 20 cycles each ----
      @(posedge clk);
      #1;
      arstn = 1'b1;
      cyc(19);
      chk("rot_e19_page", bus_if.page_sel, 0);
      chk("rot_e19_sec", bus_if.sec_left, 1);
      chk("rot_e19_chg", bus_if.page_change, 0);
      cyc(1);
      chk("rot_e20_page", bus_if.page_sel, 1);
      chk("rot_e20_sec", bus_if.sec_left, 5);
      chk("rot_e20_chg", bus_if.page_change, 1);
      chk("rot_e20_time", bus_if.disp_time, 0);
      cyc(1);
      chk("rot_e21_chg", bus_if.page_change, 0);
      cyc(19);
      chk("rot_e40_page", bus_if.page_sel, 2);
      chk("rot_e40_chg", bus_if.page_change, 1);
      cyc(20);
      chk("rot_e60_page", bus_if.page_sel, 0);
      chk("rot_e60_time", bus_if.disp_time, 1);

      // ---- message request while page 1 shows sec_left=4 ----
      apply_reset();
      cyc(24);
      chk("msg_e24_page", bus_if.page_sel, 1);
      chk("msg_e24_sec", bus_if.sec_left, 4);
      bus_if.msg_req = 1'b1;
`ifdef DISP_MSG_PREEMPT_EN
      cyc(1);
      chk("msg_pre_page", bus_if.page_sel, 3);
      chk("msg_pre_ack", bus_if.msg_ack, 1);
      chk("msg_pre_sec", bus_if.sec_left, 3);
      bus_if.msg_req = 1'b0;
      cyc(11);
      chk("msg_pre_last_page", bus_if.page_sel, 3);
      chk("msg_pre_last_done", bus_if.msg_done, 0);
`else
      cyc(15);
      chk("msg_wait_page", bus_if.page_sel, 1);
      chk("msg_wait_ack", bus_if.msg_ack, 0);
      cyc(1);
      chk("msg_entry_page", bus_if.page_sel, 3);
      chk("msg_entry_ack", bus_if.msg_ack, 1);
      chk("msg_entry_sec", bus_if.sec_left, 3);
      chk("msg_entry_chg", bus_if.page_change, 1);
      bus_if.msg_req = 1'b0;
      cyc(11);
      chk("msg_last_page", bus_if.page_sel, 3);
      chk("msg_last_sec", bus_if.sec_left, 1);
      chk("msg_last_done", bus_if.msg_done, 0);
`endif
      cyc(1);
      chk("msg_ret_page", bus_if.page_sel, 1);
      chk("msg_ret_sec", bus_if.sec_left, 5);
      chk("msg_ret_done", bus_if.msg_done, 1);
      cyc(1);
      chk("msg_ret_done_clr", bus_if.msg_done, 0);

      // ---- message request while btn_hold is high ----
      apply_reset();
      bus_if.btn_hold = 1'b1;
      bus_if.msg_req  = 1'b1;
`ifdef DISP_MSG_PREEMPT_EN
      cyc(1);
      chk("hmsg_page", bus_if.page_sel, 3);
      chk("hmsg_ack", bus_if.msg_ack, 1);
      bus_if.msg_req = 1'b0;
      cyc(12);
      chk("hmsg_ret_page", bus_if.page_sel, 0);
      chk("hmsg_ret_done", bus_if.msg_done, 1);
      cyc(8);
      chk("hmsg_hold_sec", bus_if.sec_left, 5);
`else
      cyc(30);
      chk("hmsg_blocked_page", bus_if.page_sel, 0);
      chk("hmsg_blocked_sec", bus_if.sec_left, 5);
      chk("hmsg_blocked_ack", bus_if.msg_ack, 0);
`endif
      clear_inputs();

      // ---- hold, next during hold, release ----
      apply_reset();
      cyc(8);
      chk("hold_e8_sec", bus_if.sec_left, 3);
      bus_if.btn_hold = 1'b1;
      cyc(40);
      chk("hold_frozen_sec", bus_if.sec_left, 3);
      chk("hold_frozen_page", bus_if.page_sel, 0);
      bus_if.btn_next = 1'b1;
      cyc(1);
      bus_if.btn_next = 1'b0;
      chk("hold_next_page", bus_if.page_sel, 1);
      chk("hold_next_sec", bus_if.sec_left, 5);
      cyc(10);
      chk("hold_next_frozen", bus_if.sec_left, 5);
      bus_if.btn_hold = 1'b0;
      cyc(4);
      chk("hold_rel_sec5", bus_if.sec_left, 5);
      cyc(1);
      chk("hold_rel_sec4", bus_if.sec_left, 4);

      // ---- expiry + btn_next + msg_req together, then reset mid-message ----
      apply_reset();
      cyc(19);
      bus_if.btn_next = 1'b1;
      bus_if.msg_req  = 1'b1;
      cyc(1);
      bus_if.btn_next = 1'b0;
      bus_if.msg_req  = 1'b0;
      chk("coin_page", bus_if.page_sel, 3);
      chk("coin_ack", bus_if.msg_ack, 1);
      chk("coin_sec", bus_if.sec_left, 3);
      cyc(2);
      chk("coin_stay_page", bus_if.page_sel, 3);
      chk("coin_stay_sec", bus_if.sec_left, 3);
      arstn = 1'b0;
      #1;
      chk("mrst_page", bus_if.page_sel, 0);
      chk("mrst_sec", bus_if.sec_left, 5);
      cyc(3);
      chk("mrst_done", bus_if.msg_done, 0);
      arstn = 1'b1;

      // ---- dwell configuration ----
      cfg_write(2'd1, 8'd0);
      cyc(19);
      chk("cfg_skip_page", bus_if.page_sel, 2);
      chk("cfg_skip_sec", bus_if.sec_left, 5);
      cyc(20);
      chk("cfg_wrap_page", bus_if.page_sel, 0);
      cfg_write(2'd0, 8'd2);
      chk("cfg_live_sec", bus_if.sec_left, 5);
      cyc(19);
      chk("cfg_p2_page", bus_if.page_sel, 2);
      cyc(20);
      chk("cfg_new_page", bus_if.page_sel, 0);
      chk("cfg_new_sec", bus_if.sec_left, 2);
      cfg_write(2'd0, 8'd0);
      cfg_write(2'd2, 8'd0);
      cyc(5);
      chk("zero_e87_sec", bus_if.sec_left, 1);
      cyc(1);
      chk("zero_load_page", bus_if.page_sel, 0);
      chk("zero_load_sec", bus_if.sec_left, 0);
      chk("zero_load_chg", bus_if.page_change, 1);
      bus_if.btn_next = 1'b1;
      cyc(1);
      bus_if.btn_next = 1'b0;
      chk("zero_next_page", bus_if.page_sel, 0);
      chk("zero_next_chg", bus_if.page_change, 0);
      cyc(20);
      chk("zero_stay_page", bus_if.page_sel, 0);
      chk("zero_stay_sec", bus_if.sec_left, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
